// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - preset MM:SS countdown in 10 ms steps with BCD digit outputs and expiry flag
module countdown_timer #(
    parameter int TICK_COUNT = 999_999
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        load,
    input  logic        start_pause,
    input  logic [15:0] preset,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic [3:0]  tenths,
    output logic [3:0]  hunds,
    output logic        running,
    output logic        expired,
    output logic        expired_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    localparam int PW = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_COUNT);

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [3:0]      mt_q, mo_q, st_q, so_q, te_q, hu_q;
    logic [3:0]      mt_d, mo_d, st_d, so_d, te_d, hu_d;
    logic            pulse_q;
    logic            load_ok, sp_ok, tick, last_step;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    always_comb begin
        load_ok   = load && (state_q != S_RUN);
        sp_ok     = start_pause && !load;
        tick      = (state_q == S_RUN) && (pre_q == PRE_MAX);
        last_step = ({mt_q, mo_q, st_q, so_q, te_q} == 20'h0) && (hu_q == 4'd1);
    end

    always_comb begin
        mt_d  = mt_q;
        mo_d  = mo_q;
        st_d  = st_q;
        so_d  = so_q;
        te_d  = te_q;
        hu_d  = hu_q;
        pre_d = pre_q;
        if (load_ok) begin
            mt_d  = clamp(preset[15:12], 4'd5);
            mo_d  = clamp(preset[11:8], 4'd9);
            st_d  = clamp(preset[7:4], 4'd5);
            so_d  = clamp(preset[3:0], 4'd9);
            te_d  = 4'd0;
            hu_d  = 4'd0;
            pre_d = '0;
        end else if (state_q == S_RUN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                // Borrow ripples up; min_tens cannot underflow since expiry halts at zero
                if (hu_q != 4'd0) hu_d = hu_q - 4'd1;
                else begin
                    hu_d = 4'd9;
                    if (te_q != 4'd0) te_d = te_q - 4'd1;
                    else begin
                        te_d = 4'd9;
                        if (so_q != 4'd0) so_d = so_q - 4'd1;
                        else begin
                            so_d = 4'd9;
                            if (st_q != 4'd0) st_d = st_q - 4'd1;
                            else begin
                                st_d = 4'd5;
                                if (mo_q != 4'd0) mo_d = mo_q - 4'd1;
                                else begin
                                    mo_d = 4'd9;
                                    mt_d = mt_q - 4'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_ok) begin
            state_d = (preset != 16'h0) ? S_PAUSE : S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (tick && last_step) state_d = S_EXPIRED;
                    else if (sp_ok)        state_d = S_PAUSE;
                end
                S_PAUSE: if (sp_ok) state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            te_q    <= 4'd0;
            hu_q    <= 4'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            te_q    <= te_d;
            hu_q    <= hu_d;
            pulse_q <= (state_d == S_EXPIRED) && (state_q != S_EXPIRED);
        end
    end

    always_comb begin
        running       = (state_q == S_RUN);
        expired       = (state_q == S_EXPIRED);
        expired_pulse = pulse_q;
        min_tens      = mt_q;
        min_ones      = mo_q;
        sec_tens      = st_q;
        sec_ones      = so_q;
        tenths        = te_q;
        hunds         = hu_q;
    end

endmodule
